// File: rtl/music_pkg.sv
// Shared widths and sequencer state encoding for the song reader.
package music_pkg;

  localparam int unsigned SongW     = 2;
  localparam int unsigned NoteAddrW = 5;
  localparam int unsigned NoteW     = 6;
  localparam int unsigned DurW      = 6;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLatch = 3'd2,
    StEmit  = 3'd3,
    StWait  = 3'd4,
    StNext  = 3'd5,
    StDone  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/song_reader_seq.sv
// Walks a song stored in an external synchronous ROM and hands each note to the player,
// one at a time, with pause, song switching, repeat and end-of-song reporting.
module song_reader_seq
  import music_pkg::*;
#(
  parameter int unsigned SONG_W      = SongW,
  parameter int unsigned NOTE_ADDR_W = NoteAddrW,
  parameter int unsigned NOTE_W      = NoteW,
  parameter int unsigned DUR_W       = DurW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          play,
  input  logic [SONG_W-1:0]             song,
  input  logic                          repeat_en,
  input  logic                          note_done,
  output logic [SONG_W+NOTE_ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]             rom_note,
  input  logic [DUR_W-1:0]              rom_dur,
  output logic                          new_note,
  output logic [NOTE_W-1:0]             note,
  output logic [DUR_W-1:0]              duration,
  output logic                          song_done,
  output logic                          busy
);

  seq_state_e             state_q;
  logic [NOTE_ADDR_W-1:0] index_q;
  logic [SONG_W-1:0]      cur_song_q;

  assign busy     = state_q inside {StFetch, StLatch, StEmit, StWait, StNext};
  assign rom_addr = {cur_song_q, index_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      index_q    <= '0;
      cur_song_q <= '0;
      note       <= '0;
      duration   <= '0;
      new_note   <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (busy && play && (song != cur_song_q)) begin
        index_q    <= '0;
        cur_song_q <= song;
        state_q    <= StFetch;
      end else if (busy && !play) begin
        // Paused: everything holds, pulses stay low, note_done is dropped.
      end else begin
        case (state_q)
          StIdle: begin
            index_q <= '0;
            if (play) begin
              cur_song_q <= song;
              state_q    <= StFetch;
            end
          end
          StFetch: state_q <= StLatch;
          StLatch: begin
            if (rom_dur == '0) begin
              // An empty song never loops, even with repeat enabled.
              if (repeat_en && (index_q != '0)) begin
                index_q <= '0;
                state_q <= StFetch;
              end else begin
                song_done <= 1'b1;
                state_q   <= StDone;
              end
            end else begin
              note     <= rom_note;
              duration <= rom_dur;
              state_q  <= StEmit;
            end
          end
          StEmit: begin
            new_note <= 1'b1;
            state_q  <= StWait;
          end
          StWait: begin
            if (note_done) state_q <= StNext;
          end
          StNext: begin
            if (index_q == '1) begin
              if (repeat_en) begin
                index_q <= '0;
                state_q <= StFetch;
              end else begin
                song_done <= 1'b1;
                state_q   <= StDone;
              end
            end else begin
              index_q <= index_q + 1'b1;
              state_q <= StFetch;
            end
          end
          StDone: begin
            if (!play) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader_seq.sv
// Directed bench for song_reader_seq with a behavioural synchronous song ROM.
module tb_song_reader_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       play;
  logic [1:0] song;
  logic       repeat_en;
  logic       note_done;
  logic [6:0] rom_addr;
  logic [5:0] rom_note;
  logic [5:0] rom_dur;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       song_done;
  logic       busy;

  int tests  = 0;
  int failed = 0;
  int n;
  bit saw_done;

  logic [5:0] mem_note [128];
  logic [5:0] mem_dur  [128];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_note <= mem_note[rom_addr];
    rom_dur  <= mem_dur[rom_addr];
  end

  song_reader_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .song      (song),
    .repeat_en (repeat_en),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .rom_dur   (rom_dur),
    .new_note  (new_note),
    .note      (note),
    .duration  (duration),
    .song_done (song_done),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_new_note(output int cnt, output bit done_seen);
    cnt = 0;
    done_seen = 1'b0;
    do begin
      step();
      cnt++;
      if (song_done) done_seen = 1'b1;
    end while (!new_note && cnt < 40);
  endtask

  task automatic wait_song_done(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!song_done && cnt < 40);
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_note[i] = '0;
      mem_dur[i]  = '0;
    end
    mem_note[32] = 6'd5;  mem_dur[32] = 6'd3;
    mem_note[33] = 6'd9;  mem_dur[33] = 6'd2;
    mem_note[64] = 6'd12; mem_dur[64] = 6'd4;
    mem_note[65] = 6'd13; mem_dur[65] = 6'd1;
    for (int i = 0; i < 32; i++) begin
      mem_note[96+i] = 6'(i + 1);
      mem_dur[96+i]  = 6'd1;
    end

    reset_n = 1'b0; play = 1'b0; song = 2'd0; repeat_en = 1'b0; note_done = 1'b0;
    step();
    step();
    check("reset_busy", 32'(busy), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    check("reset_note", 32'(note), 0);
    check("reset_new_note", 32'(new_note), 0);
    reset_n = 1'b1;
    step();

    // Song 1, no repeat: two notes then song_done
    song = 2'd1; play = 1'b1;
    step();
    check("fetch_busy", 32'(busy), 1);
    check("fetch_addr", 32'(rom_addr), 32);
    wait_new_note(n, saw_done);
    check("first_note_cycles", 32'(n), 3);
    check("first_note", 32'(note), 5);
    check("first_dur", 32'(duration), 3);
    step();
    check("new_note_one_cycle", 32'(new_note), 0);
    pulse_done();
    wait_new_note(n, saw_done);
    check("second_note_cycles", 32'(n), 4);
    check("second_note", 32'(note), 9);
    check("second_dur", 32'(duration), 2);
    pulse_done();
    wait_song_done(n);
    check("song_done_cycles", 32'(n), 3);
    check("done_busy", 32'(busy), 0);
    step();
    check("song_done_pulse", 32'(song_done), 0);
    check("done_no_new_note", 32'(new_note), 0);
    play = 1'b0;
    step();
    check("idle_busy", 32'(busy), 0);

    // Same song with repeat: play-to-new_note latency and wrap to index 0
    repeat_en = 1'b1; play = 1'b1;
    wait_new_note(n, saw_done);
    check("latency_k3", 32'(n), 4);
    pulse_done();
    wait_new_note(n, saw_done);
    check("rep_second_note", 32'(note), 9);
    pulse_done();
    wait_new_note(n, saw_done);
    check("rep_wrap_cycles", 32'(n), 6);
    check("rep_wrap_note", 32'(note), 5);
    check("rep_wrap_addr", 32'(rom_addr), 32);
    check("rep_no_song_done", 32'(saw_done), 0);

    // Pause in WAIT with note_done asserted throughout
    play = 1'b0; note_done = 1'b1;
    repeat (10) step();
    check("pause_busy", 32'(busy), 1);
    check("pause_addr", 32'(rom_addr), 32);
    check("pause_new_note", 32'(new_note), 0);
    note_done = 1'b0; play = 1'b1;
    repeat (3) step();
    check("resume_hold", 32'(new_note), 0);
    pulse_done();
    wait_new_note(n, saw_done);
    check("resume_cycles", 32'(n), 4);
    check("resume_note", 32'(note), 9);
    check("resume_addr", 32'(rom_addr), 33);

    // Switch to song 2 while waiting on a note
    repeat_en = 1'b0; song = 2'd2;
    step();
    check("switch_addr", 32'(rom_addr), 64);
    wait_new_note(n, saw_done);
    check("switch_cycles", 32'(n), 3);
    check("switch_note", 32'(note), 12);
    check("switch_dur", 32'(duration), 4);
    pulse_done();
    wait_new_note(n, saw_done);
    check("s2_second_note", 32'(note), 13);
    pulse_done();
    wait_song_done(n);
    check("s2_done_cycles", 32'(n), 3);
    play = 1'b0;
    step();

    // Full 32-note song ends on the index limit
    song = 2'd3; play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_new_note(n, saw_done);
      check("full_note", 32'(note), 32'(i + 1));
      pulse_done();
    end
    wait_song_done(n);
    check("full_done_cycles", 32'(n), 1);
    check("full_done_addr", 32'(rom_addr), 127);
    check("full_done_busy", 32'(busy), 0);
    play = 1'b0;
    step();

    // Terminator at index 0 with repeat enabled must still finish
    song = 2'd0; repeat_en = 1'b1; play = 1'b1;
    wait_song_done(n);
    check("empty_done_cycles", 32'(n), 3);
    check("empty_busy", 32'(busy), 0);
    play = 1'b0; repeat_en = 1'b0;
    step();

    // Asynchronous reset while a new_note pulse is out
    song = 2'd1; play = 1'b1;
    wait_new_note(n, saw_done);
    check("pre_reset_new_note", 32'(new_note), 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_new_note", 32'(new_note), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_note", 32'(note), 0);
    check("rst_dur", 32'(duration), 0);
    play = 1'b0;
    #2 reset_n = 1'b1;
    step();
    step();
    check("post_rst_idle", 32'(busy), 0);
    check("post_rst_new_note", 32'(new_note), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
